// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and widths used by the fetch stage.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package rv32i_pkg;

  localparam int DPW    = 32;
  localparam int ILEN   = 32;
  localparam int PC_INC = 4;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    SQUASH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response port between fetch control and imem.
// Request is valid/ready; response is a single pulse per accepted request.
// Response has no backpressure: the requester must always take it.
interface fetch_ctrl_if #(
  parameter int DPW  = rv32i_pkg::DPW,
  parameter int ILEN = rv32i_pkg::ILEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [DPW-1:0]  imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_ctrl_sva.sv
// Protocol checker bound into fetch_ctrl: outstanding count, address tie, flush scope.
// Observes only; adds no latency to the datapath.
// Does not drive any handshake signal.
module fetch_ctrl_sva
  import rv32i_pkg::*;
#(
  parameter int DPW = rv32i_pkg::DPW
) (
  input logic           clk,
  input logic           rst_n,
  input fetch_state_t   state,
  input logic           flushF,
  input logic           req_valid,
  input logic           req_ready,
  input logic           rsp_valid,
  input logic [DPW-1:0] req_addr,
  input logic [DPW-1:0] pcf
);

  logic [1:0] r_outstanding;

  // Track accepted-but-unanswered requests; a stray response never underflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      unique case ({req_valid && req_ready, rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   if (r_outstanding != 2'd0) r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    req_valid |-> (r_outstanding == 2'd0));

  a_addr_is_pcf: assert property (@(posedge clk) disable iff (!rst_n)
    req_addr == pcf);

  a_flush_only_boot: assert property (@(posedge clk) disable iff (!rst_n)
    flushF |-> (state == BOOT));

  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_valid && (state == REQ)));

endmodule

bind fetch_ctrl fetch_ctrl_sva #(.DPW(DPW)) u_fetch_ctrl_sva (
  .clk       (clk),
  .rst_n     (rst_n),
  .state     (r_state),
  .flushF    (flushF),
  .req_valid (w_req_valid),
  .req_ready (w_req_ready),
  .rsp_valid (w_rsp_valid),
  .req_addr  (w_req_addr),
  .pcf       (PCF)
);

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives PCNext/stallF/flushF and one imem request at a time.
// Outputs are combinational from state and inputs; instruction is delivered the cycle the response arrives.
// Holds a response in a one-entry buffer while decode stalls; redirects always win over delivery.
module fetch_ctrl #(
  parameter int DPW  = rv32i_pkg::DPW,
  parameter int ILEN = rv32i_pkg::ILEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DPW-1:0]  PCF,
  input  logic            redirect_valid,
  input  logic [DPW-1:0]  redirect_pc,
  input  logic            stallD,
  fetch_ctrl_if.master    imem,
  output logic [DPW-1:0]  PCNext,
  output logic            stallF,
  output logic            flushF,
  output logic            instr_valid,
  output logic [ILEN-1:0] instrF,
  output logic [DPW-1:0]  instr_pc
);
  import rv32i_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [ILEN-1:0] r_hold;
  logic            w_hold_load;
  logic            w_req_valid;
  logic            w_req_ready;
  logic            w_rsp_valid;
  logic [ILEN-1:0] w_rsp_data;
  logic [DPW-1:0]  w_req_addr;
  logic [DPW-1:0]  w_pc_seq;

  assign w_req_ready         = imem.imem_req_ready;
  assign w_rsp_valid         = imem.imem_rsp_valid;
  assign w_rsp_data          = imem.imem_rsp_data;
  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = w_req_addr;

  // The request address and the delivered PC are both the live PC register
  // value; PCF only moves once the instruction has left this block.
  assign w_req_addr = PCF;
  assign instr_pc   = PCF;
  assign w_pc_seq   = PCF + DPW'(PC_INC);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // Hold buffer: captures the response when decode cannot take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_hold <= '0;
    else if (w_hold_load) r_hold <= w_rsp_data;
  end

  // Next state and all fetch-side outputs; defaults hold the PC and idle imem.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_load = 1'b0;
    w_req_valid = 1'b0;
    PCNext      = PCF;
    stallF      = 1'b1;
    flushF      = 1'b0;
    instr_valid = 1'b0;
    instrF      = '0;

    unique case (r_state)
      BOOT: begin
        // Flush loads PC=0; any redirect or stray response is ignored.
        flushF      = 1'b1;
        stallF      = 1'b0;
        PCNext      = '0;
        w_state_nxt = REQ;
      end

      REQ: begin
        if (redirect_valid) begin
          stallF = 1'b0;
          PCNext = redirect_pc;
        end else begin
          w_req_valid = 1'b1;
          if (w_req_ready) w_state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (w_rsp_valid) begin
          if (redirect_valid) begin
            // Wrong-path instruction: drop it and go fetch the target.
            stallF      = 1'b0;
            PCNext      = redirect_pc;
            w_state_nxt = REQ;
          end else if (!stallD) begin
            instr_valid = 1'b1;
            instrF      = w_rsp_data;
            stallF      = 1'b0;
            PCNext      = w_pc_seq;
            w_state_nxt = REQ;
          end else begin
            instr_valid = 1'b1;
            instrF      = w_rsp_data;
            w_hold_load = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          // The in-flight response is now stale; wait it out before re-requesting.
          stallF      = 1'b0;
          PCNext      = redirect_pc;
          w_state_nxt = SQUASH;
        end
      end

      SQUASH: begin
        if (redirect_valid) begin
          stallF = 1'b0;
          PCNext = redirect_pc;
        end
        if (w_rsp_valid) w_state_nxt = REQ;
      end

      HOLD: begin
        instr_valid = 1'b1;
        instrF      = r_hold;
        if (redirect_valid) begin
          instr_valid = 1'b0;
          stallF      = 1'b0;
          PCNext      = redirect_pc;
          w_state_nxt = REQ;
        end else if (!stallD) begin
          stallF      = 1'b0;
          PCNext      = w_pc_seq;
          w_state_nxt = REQ;
        end
      end

      default: w_state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a PC register and a latency-programmable imem.
// Directed scenarios first, then a randomized run checked against a program-order model.
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stallD;
  logic [31:0] PCNext;
  logic        stallF;
  logic        flushF;
  logic        instr_valid;
  logic [31:0] instrF;
  logic [31:0] instr_pc;

  int total = 0;
  int bad   = 0;

  // imem model state: one pending response with a countdown
  int          lat   = 1;
  logic        pend  = 1'b0;
  int          cnt   = 0;
  logic [31:0] paddr = 32'h0;

  fetch_ctrl_if #(.DPW(32), .ILEN(32)) imem_if ();

  fetch_ctrl #(.DPW(32), .ILEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCF            (PCF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stallD         (stallD),
    .imem           (imem_if.master),
    .PCNext         (PCNext),
    .stallF         (stallF),
    .flushF         (flushF),
    .instr_valid    (instr_valid),
    .instrF         (instrF),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  // PC register sibling: flush clears, stall holds, otherwise load PCNext.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      PCF <= 32'h0;
    else if (flushF) PCF <= 32'h0;
    else if (!stallF) PCF <= PCNext;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h20) return 32'h0050_0093;
    return (a * 32'h0001_0001) ^ 32'h0000_0013 ^ {a[9:2], 24'h0};
  endfunction

  // imem: respond 'lat' cycles after an accepted request; sample accept late in the cycle.
  initial begin
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      imem_if.imem_rsp_valid = 1'b0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          imem_if.imem_rsp_valid = 1'b1;
          imem_if.imem_rsp_data  = mem(paddr);
          pend = 1'b0;
        end
      end
      #4;
      if (rst_n && imem_if.imem_req_valid && imem_if.imem_req_ready) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_if.imem_req_addr;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (flushF !== 1'b1 || stallF !== 1'b0 || imem_if.imem_req_valid !== 1'b0 ||
        instr_valid !== 1'b0 || instrF !== 32'h0 || PCNext !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: fl=%b st=%b rv=%b iv=%b i=%h nx=%h want 1 0 0 0 0 0",
               flushF, stallF, imem_if.imem_req_valid, instr_valid, instrF, PCNext);
    end
    @(negedge clk);
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    #1;
    total++;
    if (flushF !== 1'b1 || stallF !== 1'b0 || PCNext !== 32'h0 || imem_if.imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL boot_cycle: fl=%b st=%b nx=%h rv=%b want 1 0 0 0",
               flushF, stallF, PCNext, imem_if.imem_req_valid);
    end
  endtask

  task automatic test_seq();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      total++;
      if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== 32'(4*i) ||
          instr_valid !== 1'b0 || flushF !== 1'b0) begin
        bad++;
        $display("FAIL seq_req%0d: rv=%b a=%h iv=%b fl=%b want 1 %h 0 0", i,
                 imem_if.imem_req_valid, imem_if.imem_req_addr, instr_valid, flushF, 32'(4*i));
      end
      @(negedge clk);
      #1;
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4*i) || instrF !== mem(32'(4*i)) ||
          PCNext !== 32'(4*i+4) || stallF !== 1'b0) begin
        bad++;
        $display("FAIL seq_rsp%0d: iv=%b pc=%h d=%h nx=%h st=%b want 1 %h %h %h 0", i,
                 instr_valid, instr_pc, instrF, PCNext, stallF,
                 32'(4*i), mem(32'(4*i)), 32'(4*i+4));
      end
    end
  endtask

  task automatic test_ready_stall();
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
    #1;
    total++;
    if (imem_if.imem_req_valid !== 1'b0 || PCNext !== 32'h10 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL req_redirect: rv=%b nx=%h st=%b want 0 00000010 0",
               imem_if.imem_req_valid, PCNext, stallF);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      total++;
      if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== 32'h10 ||
          stallF !== 1'b1 || PCF !== 32'h10) begin
        bad++;
        $display("FAIL ready_low%0d: rv=%b a=%h st=%b pc=%h want 1 10 1 10", i,
                 imem_if.imem_req_valid, imem_if.imem_req_addr, stallF, PCF);
      end
    end
    @(negedge clk);
    imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instrF !== mem(32'h10)) begin
      bad++;
      $display("FAIL ready_rsp: iv=%b pc=%h d=%h want 1 10 %h", instr_valid, instr_pc, instrF, mem(32'h10));
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0; imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (instr_valid !== 1'b1 || instrF !== 32'h0050_0093 || instr_pc !== 32'h20 ||
          stallF !== 1'b1 || PCF !== 32'h20) begin
        bad++;
        $display("FAIL hold%0d: iv=%b d=%h pc=%h st=%b want 1 00500093 20 1", i,
                 instr_valid, instrF, instr_pc, stallF);
      end
      @(negedge clk);
    end
    stallD = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b1 || instrF !== 32'h0050_0093 || PCNext !== 32'h24 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: iv=%b d=%h nx=%h st=%b want 1 00500093 24 0",
               instr_valid, instrF, PCNext, stallF);
    end
    @(negedge clk);
    #1;
    total++;
    if (PCF !== 32'h24 || instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_after: pc=%h iv=%b rv=%b want 24 0 1", PCF, instr_valid, imem_if.imem_req_valid);
    end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h30;
    @(negedge clk);
    redirect_valid = 1'b0; imem_if.imem_req_ready = 1'b1; lat = 3;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++;
    if (instr_valid !== 1'b0 || PCNext !== 32'h100 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL wait_redirect: iv=%b nx=%h st=%b want 0 100 0", instr_valid, PCNext, stallF);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      total++;
      if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b0 || PCF !== 32'h100) begin
        bad++;
        $display("FAIL squash%0d: iv=%b rv=%b pc=%h want 0 0 100", i,
                 instr_valid, imem_if.imem_req_valid, PCF);
      end
    end
    @(negedge clk);
    lat = 1;
    #1;
    total++;
    if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== 32'h100) begin
      bad++;
      $display("FAIL squash_next_req: rv=%b a=%h want 1 100", imem_if.imem_req_valid, imem_if.imem_req_addr);
    end
  endtask

  task automatic test_redirect_rsp();
    @(negedge clk);
    imem_if.imem_req_ready = 1'b1; lat = 1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    total++;
    if (instr_valid !== 1'b0 || PCNext !== 32'h200 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL rsp_redirect: iv=%b nx=%h st=%b want 0 200 0", instr_valid, PCNext, stallF);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++;
    if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_redirect_req: rv=%b a=%h iv=%b want 1 200 0",
               imem_if.imem_req_valid, imem_if.imem_req_addr, instr_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0; imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; stallD = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    total++;
    if (instr_valid !== 1'b0 || PCNext !== 32'h200 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL hold_redirect: iv=%b nx=%h st=%b want 0 200 0", instr_valid, PCNext, stallF);
    end
    @(negedge clk);
    redirect_valid = 1'b0; stallD = 1'b0;
    #1;
    total++;
    if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_redirect_req: rv=%b a=%h iv=%b want 1 200 0",
               imem_if.imem_req_valid, imem_if.imem_req_addr, instr_valid);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; imem_if.imem_req_ready = 1'b1;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instrF !== mem(32'hFFFF_FFFC) ||
        PCNext !== 32'h0 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL wrap: iv=%b pc=%h d=%h nx=%h st=%b want 1 fffffffc %h 0 0",
               instr_valid, instr_pc, instrF, PCNext, stallF, mem(32'hFFFF_FFFC));
    end
    @(negedge clk);
    #1;
    total++;
    if (PCF !== 32'h0 || imem_if.imem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next: pc=%h a=%h want 0 0", PCF, imem_if.imem_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    imem_if.imem_req_ready = 1'b1; lat = 4;
    @(negedge clk);
    imem_if.imem_req_ready = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if (flushF !== 1'b1 || PCNext !== 32'h0 || instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset: fl=%b nx=%h iv=%b rv=%b want 1 0 0 0",
               flushF, PCNext, instr_valid, imem_if.imem_req_valid);
    end
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (flushF !== 1'b1 || instr_valid !== 1'b0 || instrF !== 32'h0 || stallF !== 1'b0) begin
      bad++;
      $display("FAIL boot_rsp_ignored: fl=%b iv=%b d=%h st=%b want 1 0 0 0", flushF, instr_valid, instrF, stallF);
    end
    @(negedge clk);
    lat = 1;
    #1;
    total++;
    if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== 32'h0 || flushF !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_midreset: rv=%b a=%h fl=%b iv=%b want 1 0 0 0",
               imem_if.imem_req_valid, imem_if.imem_req_addr, flushF, instr_valid);
    end
  endtask

  // Program-order model: every consumed instruction is the successor of the
  // previous one, or the target of the most recent redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    int          got = 0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h400; stallD = 1'b0;
    exp_pc = 32'h400;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      imem_if.imem_req_ready = ($urandom % 4) != 0;
      stallD         = ($urandom % 3) == 0;
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = (($urandom % 6) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
      #1;
      if (redirect_valid) begin
        total++;
        if (instr_valid !== 1'b0) begin
          bad++;
          $display("FAIL rnd_redirect_wins c=%0d: iv=%b want 0", c, instr_valid);
        end
      end
      if (imem_if.imem_req_valid === 1'b1) begin
        total++;
        if (pend) begin
          bad++;
          $display("FAIL rnd_outstanding c=%0d: request while %h pending", c, paddr);
        end
      end
      if (instr_valid === 1'b1 && !stallD && !redirect_valid) begin
        total++;
        if (instr_pc !== exp_pc || instrF !== mem(exp_pc)) begin
          bad++;
          $display("FAIL rnd_deliver c=%0d: pc=%h d=%h want %h %h", c, instr_pc, instrF, exp_pc, mem(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    redirect_valid = 1'b0;
    total++;
    if (got < 200) begin
      bad++;
      $display("FAIL rnd_progress: delivered=%0d want >=200", got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    stallD = 1'b0;
    imem_if.imem_req_ready = 1'b1;
    test_reset();
    test_seq();
    test_ready_stall();
    test_hold();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
